backoff_mul_pipe: RTL

- Parametrised, pipelined unsigned multiplier with valid/ready handshakes at both ends.
- Next generation of the fixed single-cycle backoff multiplier used by the EDCA backoff logic in the MAC core.
- Computes slot-count × slot-time style products for all access categories through one shared instance.
- Each operand pair carries a tag (access category) that returns with its result; stalls and flushes are supported.

---
 rtl/mac_arith_pkg.sv | 20 ++
 rtl/backoff_mul_stage.sv | 36 +++
 rtl/backoff_mul_pipe.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mac_arith_pkg.sv
// Shared arithmetic types and defaults for the MAC backoff datapath.
package mac_arith_pkg;

  typedef enum logic [1:0] {
    AC_BK = 2'd0,
    AC_BE = 2'd1,
    AC_VI = 2'd2,
    AC_VO = 2'd3
  } ac_tag_t;

  localparam int unsigned DEF_MUL_A_W = 17;
  localparam int unsigned DEF_MUL_B_W = 17;
  localparam int unsigned DEF_MUL_P_W = 32;

  // Counter width able to hold 0..n_stage inclusive.
  function automatic int unsigned occ_width(input int unsigned n_stage);
    return $clog2(n_stage + 1);
  endfunction

endpackage

// File: rtl/backoff_mul_stage.sv
// One pipeline slot: valid/data register that loads whenever it is empty or
// its contents are moving on, so bubbles collapse behind a stall.
module backoff_mul_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_up_valid,
  input  logic          i_down_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_ready_c,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  assign o_ready_c = !r_valid || i_down_ready;
  assign o_valid   = r_valid;
  assign o_data    = r_data;

  // Flush drops the valid bit only; payload may stay stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_flush)        r_valid <= 1'b0;
      else if (o_ready_c) r_valid <= i_up_valid;
      if (o_ready_c && i_up_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/backoff_mul_pipe.sv
// Pipelined tagged unsigned multiplier with valid/ready at both ends.
// Build option BACKOFF_MUL_SAT_EN saturates dout on overflow instead of truncating.
module backoff_mul_pipe
  import mac_arith_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DEF_MUL_A_W,
  parameter int unsigned DIN1_WIDTH = DEF_MUL_B_W,
  parameter int unsigned DOUT_WIDTH = DEF_MUL_P_W,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned TAG_WIDTH  = 2
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DIN0_WIDTH-1:0]             din0,
  input  logic [DIN1_WIDTH-1:0]             din1,
  input  logic [TAG_WIDTH-1:0]              in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DOUT_WIDTH-1:0]             dout,
  output logic [TAG_WIDTH-1:0]              out_tag,
  output logic                              ovf,
  output logic [occ_width(NUM_STAGE)-1:0]   occupancy
);

  localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned DW = TAG_WIDTH + 1 + PW;
  localparam int unsigned OW = occ_width(NUM_STAGE);

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [PW-1:0] w_ops_in;
  logic [DW-1:0] w_last_q;
  logic          w_unused_hi;
  logic [OW-1:0] r_occ;

  // Operands travel packed as {a, b}, which is exactly PW bits wide.
  function automatic logic [PW-1:0] mul_full(input logic [PW-1:0] ops);
    return PW'(ops[PW-1:DIN1_WIDTH]) * PW'(ops[DIN1_WIDTH-1:0]);
  endfunction

  // Returns {ovf, dout zero-extended to PW}.
  function automatic logic [PW:0] finalize(input logic [PW-1:0] p);
    logic                  ovf_bit;
    logic [DOUT_WIDTH-1:0] d;
    ovf_bit = (p >> DOUT_WIDTH) != '0;
`ifdef BACKOFF_MUL_SAT_EN
    d = ovf_bit ? '1 : p[DOUT_WIDTH-1:0];
`else
    d = p[DOUT_WIDTH-1:0];
`endif
    return {ovf_bit, PW'(d)};
  endfunction

  assign w_ops_in  = {din0, din1};
  assign w_in_xfer = in_valid && in_ready;

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    logic                 w_up_valid;
    logic                 w_down_ready;
    logic                 w_ready;
    logic                 w_valid;
    logic [TAG_WIDTH-1:0] w_tag;
    logic [PW-1:0]        w_pay;
    logic [DW-1:0]        w_d;
    logic [DW-1:0]        w_q;

    // Stage 0 holds operands; the multiply sits between stages 0 and 1.
    if (k == 0) begin : g_src
      assign w_up_valid = w_in_xfer;
      assign w_tag      = in_tag;
      if (NUM_STAGE == 1) begin : g_one
        assign w_pay = mul_full(w_ops_in);
      end else begin : g_ops
        assign w_pay = w_ops_in;
      end
    end else begin : g_src
      assign w_up_valid = g_stage[k-1].w_valid;
      assign w_tag      = g_stage[k-1].w_q[DW-1 -: TAG_WIDTH];
      if (k == 1) begin : g_mul
        assign w_pay = mul_full(g_stage[k-1].w_q[PW-1:0]);
      end else begin : g_pass
        assign w_pay = g_stage[k-1].w_q[PW-1:0];
      end
    end

    if (k == NUM_STAGE - 1) begin : g_dst
      assign w_down_ready = out_ready;
      assign w_d          = {w_tag, finalize(w_pay)};
    end else begin : g_dst
      logic w_unused_ovf;
      assign w_down_ready = g_stage[k+1].w_ready;
      assign w_d          = {w_tag, 1'b0, w_pay};
      assign w_unused_ovf = w_q[PW];
    end

    backoff_mul_stage #(.DW(DW)) u_stage (
      .clk          (ap_clk),
      .rst_n        (ap_rst_n),
      .i_flush      (flush),
      .i_up_valid   (w_up_valid),
      .i_down_ready (w_down_ready),
      .i_data       (w_d),
      .o_ready_c    (w_ready),
      .o_valid      (w_valid),
      .o_data       (w_q)
    );
  end

  assign in_ready    = g_stage[0].w_ready && !flush;
  assign out_valid   = g_stage[NUM_STAGE-1].w_valid;
  assign w_last_q    = g_stage[NUM_STAGE-1].w_q;
  assign dout        = w_last_q[DOUT_WIDTH-1:0];
  assign ovf         = w_last_q[PW];
  assign out_tag     = w_last_q[DW-1 -: TAG_WIDTH];
  assign w_unused_hi = ^(w_last_q[PW-1:0] >> DOUT_WIDTH);
  assign w_out_xfer  = out_valid && out_ready;

  // Running count of occupied slots.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  r_occ <= '0;
    else if (flush) r_occ <= '0;
    else            r_occ <= r_occ + OW'(w_in_xfer) - OW'(w_out_xfer);
  end

  assign occupancy = r_occ;

endmodule
